midi_gate_ctrl: RTL and testbench
=================================

Name: midi_gate_ctrl

Overview:
- Parses a received MIDI byte stream and drives the gate that feeds the adsr envelope generator.
- Sits between the UART/MIDI byte receiver and adsr; its outputs drive adsr.gate and the oscillator pitch and level inputs.
- Tracks held notes with last-note priority.
- Forces a short low pulse on gate whenever a new note arrives while gate is already high, so adsr restarts its attack.

Parameters:
CHANNEL, 0, MIDI channel accepted (0..15); note messages on other channels are discarded.
MAX_NOTES, 8, depth of held-note stack (1..16).
RETRIG_GAP, 4, clk cycles gate is held low on retrigger (>=1).

Ports:
clk  input  1  system clock (50 MHz)
rst  input  1  synchronous reset, active-high
data_in  input  8  received MIDI byte
data_valid  input  1  one-cycle strobe, data_in valid; may be asserted on consecutive cycles
gate  output  1  note gate to adsr
note  output  7  current (top-of-stack) note number
velocity  output  7  velocity of the most recent accepted note-on
note_count  output  5  number of held notes, 0..MAX_NOTES
retrig  output  1  one-cycle pulse on every accepted note-on

Behaviour:
- Reset: all outputs 0. Stack empty, parser IDLE, running status cleared, gap counter 0. Reset mid-message discards the partial message.
- Byte classes, evaluated only when data_valid=1:
  - 0xF8-0xFF (realtime): ignored entirely, no parser state change.
  - 0xF0-0xF7: clear running status, go to IDLE.
  - 0x80-0xEF: load running status. Expected data length is 1 for 0xCn/0xDn and 2 for all others. Go to WAIT_D1.
  - 0x00-0x7F: data byte, handled by the parser FSM below.
- Parser FSM:
  - IDLE: data bytes ignored.
  - WAIT_D1: latch the byte. If length is 1, complete the message and stay in WAIT_D1 (running status). Otherwise go to WAIT_D2.
  - WAIT_D2: complete the message and return to WAIT_D1.
- Message handling: a completed message acts only if status is 0x9n or 0x8n with n==CHANNEL.
  - 0x9n with velocity>0: note-on.
  - 0x9n with velocity==0, or any 0x8n: note-off.
  - All other completed messages are dropped.
- Completion cycle N is the cycle the last data byte is accepted. Outputs update at N+1 (registered, latency 1).
- Stack, last-note priority, entry 0 = top:
  - Note-on, note already present: remove it and push to top; count unchanged.
  - Note-on, stack full: discard the bottom (oldest) entry, then push.
  - Note-off, note present: remove it and close the gap.
  - Note-off, note absent: no effect.
- note = top entry while count>0. When count becomes 0, note and velocity hold their last values.
- velocity updates only on note-on.
- Gate and retrig:
  - Note-on with count 0 before it: gate=1 at N+1, retrig=1 at N+1.
  - Note-on with count>0: gate=0 at N+1 for RETRIG_GAP cycles, then gate=1. retrig=1 at N+1.
  - Note-on during a gap: restart the gap counter at RETRIG_GAP.
  - Note-off leaving count>0: gate unchanged, no retrigger; note switches to new top at N+1 (legato). If a gap is in progress it continues.
  - Note-off leaving count 0: gate=0 at N+1; any gap is cancelled.
- A realtime byte arriving between data bytes does not disturb message assembly.

Test Plan:
1. Reset, send 0x90,0x3C,0x64 -> at N+1: gate=1, note=0x3C, velocity=0x64, note_count=1, retrig pulses once.
2. Continue with running-status bytes 0x40,0x50 -> gate low exactly 4 cycles from N+1, then high; note=0x40, count=2. Then send 0x80,0x40,0x00 -> note=0x3C, gate stays 1, count=1. Then send 0x90,0x3C,0x00 -> gate=0, count=0, note stays 0x3C.
3. Channel and type filtering with CHANNEL=0:
   - 0x91,0x3C,0x64 -> no output change.
   - 0xC0,0x05,0x3C,0x64 (program change plus two running-status program changes) -> no output change; parser left in WAIT_D1.
4. Overflow: note-ons 0x30..0x38 (9 notes) -> count=8, note=0x38. Note-off 0x30 -> no change. Note-offs 0x31..0x38 -> count steps down to 0; gate=0 only after the last; note tracks the new top after each release.
5. Realtime interleave: 0x90,0xF8,0x3C,0xFE,0x64 -> identical response to scenario 1. Send a second note-on during its retrigger gap -> gap restarts and gate stays low RETRIG_GAP cycles from the second completion.
6. Assert rst between 0x90 and 0x3C, then send 0x3C,0x64 -> no note (running status cleared), all outputs 0. Assert rst during a gap -> gate=0, count=0 next cycle.

Source files
------------

// File: rtl/midi_gate_ctrl.sv
// midi_gate_ctrl: MIDI byte-stream parser and held-note stack that drives the
// adsr gate. Last-note priority; a new note arriving while the gate is high
// pulls the gate low for RETRIG_GAP cycles so the envelope restarts its attack.
module midi_gate_ctrl #(
    parameter int CHANNEL    = 0,
    parameter int MAX_NOTES  = 8,
    parameter int RETRIG_GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       gate,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic [4:0] note_count,
    output logic       retrig
);

    localparam int GW = (RETRIG_GAP < 2) ? 1 : $clog2(RETRIG_GAP + 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);
    localparam logic [GW-1:0] GAP_INIT = GW'(RETRIG_GAP);
    localparam logic [4:0]    FULL     = 5'(MAX_NOTES);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;

    state_t        state;
    logic [7:0]    run_status;
    logic [6:0]    d1;
    logic [6:0]    stack      [MAX_NOTES];
    logic [6:0]    push_stack [MAX_NOTES];
    logic [6:0]    pop_stack  [MAX_NOTES];
    logic [GW-1:0] gap;

    logic len1, chan_ok, complete2, note_on, note_off, found, full;
    int   pos;

    // Message decode: a 2-byte message completes when its second data byte
    // arrives in WAIT_D2; only note-on/off on our channel are acted upon.
    always_comb begin
        len1      = (run_status[7:5] == 3'b110);
        chan_ok   = (run_status[3:0] == 4'(CHANNEL));
        complete2 = data_valid && !data_in[7] && (state == WAIT_D2) && chan_ok;
        note_on   = complete2 && (run_status[7:4] == 4'h9) && (data_in[6:0] != 7'd0);
        note_off  = complete2 && ((run_status[7:4] == 4'h8) ||
                                  ((run_status[7:4] == 4'h9) && (data_in[6:0] == 7'd0)));
        full      = (note_count == FULL);
    end

    // Stack search plus the two candidate next-stack images (push to top, remove).
    always_comb begin
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < MAX_NOTES; i++) begin
            if (!found && (i < int'(note_count)) && (stack[i] == d1)) begin
                found = 1'b1;
                pos   = i;
            end
        end
        // Push: entries above the old copy (or all, if absent) slide down one;
        // a full stack loses its bottom entry naturally.
        push_stack[0] = d1;
        for (int i = 1; i < MAX_NOTES; i++)
            push_stack[i] = (found && (i > pos)) ? stack[i] : stack[i-1];
        // Remove: entries below the released note move up to close the hole.
        for (int i = 0; i < MAX_NOTES - 1; i++)
            pop_stack[i] = (i >= pos) ? stack[i+1] : stack[i];
        pop_stack[MAX_NOTES-1] = 7'd0;
    end

    // Parser FSM, note stack, gate/retrigger sequencing; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            run_status <= 8'd0;
            d1         <= 7'd0;
            gap        <= '0;
            gate       <= 1'b0;
            note       <= 7'd0;
            velocity   <= 7'd0;
            note_count <= 5'd0;
            retrig     <= 1'b0;
            for (int i = 0; i < MAX_NOTES; i++) stack[i] <= 7'd0;
        end else begin
            retrig <= 1'b0;

            if (data_valid) begin
                if (data_in >= 8'hF8) begin
                    // realtime: transparent to message assembly
                end else if (data_in >= 8'hF0) begin
                    run_status <= 8'd0;
                    state      <= IDLE;
                end else if (data_in[7]) begin
                    run_status <= data_in;
                    state      <= WAIT_D1;
                end else begin
                    case (state)
                        WAIT_D1: begin
                            d1 <= data_in[6:0];
                            if (!len1) state <= WAIT_D2;
                        end
                        WAIT_D2: state <= WAIT_D1;
                        default: ;
                    endcase
                end
            end

            // Gap countdown; gate returns high as the last gap cycle ends.
            if (gap != '0) begin
                gap <= gap - GAP_ONE;
                if (gap == GAP_ONE) gate <= 1'b1;
            end

            if (note_on) begin
                for (int i = 0; i < MAX_NOTES; i++) stack[i] <= push_stack[i];
                note     <= d1;
                velocity <= data_in[6:0];
                retrig   <= 1'b1;
                if (!found && !full) note_count <= note_count + 5'd1;
                if (note_count == 5'd0) begin
                    gate <= 1'b1;
                    gap  <= '0;
                end else begin
                    gate <= 1'b0;
                    gap  <= GAP_INIT;
                end
            end else if (note_off && found) begin
                for (int i = 0; i < MAX_NOTES; i++) stack[i] <= pop_stack[i];
                note_count <= note_count - 5'd1;
                if (note_count == 5'd1) begin
                    // last key released: note/velocity hold, any gap is cancelled
                    gate <= 1'b0;
                    gap  <= '0;
                end else begin
                    note <= pop_stack[0];
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_gate_ctrl.sv
// Directed bench for midi_gate_ctrl: inputs change and outputs are sampled on
// the falling edge; every expectation is a hand-computed constant.
module tb_midi_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       gate;
    logic [6:0] note;
    logic [6:0] velocity;
    logic [4:0] note_count;
    logic       retrig;

    int n_assert = 0;
    int n_fail   = 0;

    midi_gate_ctrl #(.CHANNEL(0), .MAX_NOTES(8), .RETRIG_GAP(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .gate(gate), .note(note), .velocity(velocity),
        .note_count(note_count), .retrig(retrig)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Present one byte for exactly one clock; back-to-back calls give
    // data_valid on consecutive cycles.
    task automatic send(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic chk_all(input string tag, input logic g, input logic [6:0] n,
                           input logic [6:0] v, input logic [4:0] c, input logic r);
        chk({tag, ".gate"},  32'(gate),       32'(g));
        chk({tag, ".note"},  32'(note),       32'(n));
        chk({tag, ".vel"},   32'(velocity),   32'(v));
        chk({tag, ".count"}, 32'(note_count), 32'(c));
        chk({tag, ".retrig"},32'(retrig),     32'(r));
    endtask

    initial begin
        rst = 1'b1; data_in = 8'h00; data_valid = 1'b0;
        step(); step();
        rst = 1'b0;
        chk_all("reset", 1'b0, 7'h00, 7'h00, 5'd0, 1'b0);

        // 1: first note-on
        send(8'h90); send(8'h3C); send(8'h64);
        chk_all("s1", 1'b1, 7'h3C, 7'h64, 5'd1, 1'b1);
        step();
        chk("s1.retrig_off", 32'(retrig), 32'd0);
        chk("s1.gate_hold",  32'(gate),   32'd1);

        // 2: running-status second note -> 4-cycle gap
        send(8'h40); send(8'h50);
        chk_all("s2.on", 1'b0, 7'h40, 7'h50, 5'd2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s2.gap_low", 32'(gate), 32'd0);
        end
        step();
        chk("s2.gap_end", 32'(gate), 32'd1);
        chk("s2.retrig_off", 32'(retrig), 32'd0);
        send(8'h80); send(8'h40); send(8'h00);
        chk_all("s2.legato", 1'b1, 7'h3C, 7'h50, 5'd1, 1'b0);
        send(8'h90); send(8'h3C); send(8'h00);
        chk_all("s2.alloff", 1'b0, 7'h3C, 7'h50, 5'd0, 1'b0);

        // 3: other channel and non-note messages are dropped
        send(8'h91); send(8'h3C); send(8'h64);
        chk_all("s3.chan", 1'b0, 7'h3C, 7'h50, 5'd0, 1'b0);
        send(8'hC0); send(8'h05); send(8'h3C); send(8'h64);
        chk_all("s3.pgm", 1'b0, 7'h3C, 7'h50, 5'd0, 1'b0);

        // 4: overflow, then release from the top down
        send(8'h90);
        for (int k = 0; k < 9; k++) begin
            send(8'h30 + 8'(k)); send(8'h64);
        end
        chk_all("s4.full", 1'b0, 7'h38, 7'h64, 5'd8, 1'b1);
        step(); step(); step(); step();
        chk("s4.gate_up", 32'(gate), 32'd1);
        send(8'h30); send(8'h00);
        chk("s4.off_absent.count", 32'(note_count), 32'd8);
        chk("s4.off_absent.note",  32'(note),       32'h38);
        for (int j = 0; j < 8; j++) begin
            send(8'h38 - 8'(j)); send(8'h00);
            chk("s4.rel.count", 32'(note_count), 32'(7 - j));
            chk("s4.rel.note",  32'(note),       (j < 7) ? 32'(8'h37 - 8'(j)) : 32'h31);
            chk("s4.rel.gate",  32'(gate),       (j < 7) ? 32'd1 : 32'd0);
        end

        // 5: realtime bytes inside a message, then note-on during a gap
        send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
        chk_all("s5.rt", 1'b1, 7'h3C, 7'h64, 5'd1, 1'b1);
        step();
        chk("s5.retrig_off", 32'(retrig), 32'd0);
        send(8'h3E); send(8'h50);
        chk_all("s5.gap1", 1'b0, 7'h3E, 7'h50, 5'd2, 1'b1);
        send(8'h40); send(8'h51);
        chk_all("s5.gap2", 1'b0, 7'h40, 7'h51, 5'd3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s5.restart_low", 32'(gate), 32'd0);
        end
        step();
        chk("s5.restart_end", 32'(gate), 32'd1);

        // 6: reset during a gap, then reset mid-message
        send(8'h42); send(8'h52);
        chk("s6.in_gap", 32'(gate), 32'd0);
        rst = 1'b1;
        step();
        chk_all("s6.rst_gap", 1'b0, 7'h00, 7'h00, 5'd0, 1'b0);
        rst = 1'b0;
        send(8'h90);
        rst = 1'b1;
        step();
        rst = 1'b0;
        send(8'h3C); send(8'h64);
        chk_all("s6.rst_msg", 1'b0, 7'h00, 7'h00, 5'd0, 1'b0);
        step();
        chk_all("s6.rst_msg2", 1'b0, 7'h00, 7'h00, 5'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
